// File: rtl/dlx_pkg.sv
// Shared DLX register-file types and constants.
// Holds the register index type, default writeback width, the r0 index
// and the writeback-source enum used by the write-port arbiter.
package dlx_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  // Which requester owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LU   = 2'd2
  } wb_src_e;

endpackage

// File: rtl/regs_busy_table.sv
// Busy-bit table of in-flight destination registers.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   set_idx             register marked busy at the edge (0 = none)
//   clr_idx             register released at the edge (0 = none)
//   rs1/rs2/rs3         source lookups, answered against the post-release view
//   rd                  WAW lookup, answered against the post-release view
//   rs*_busy, rd_busy   lookup results
//   clr_busy            busy state of clr_idx before release (spurious-release check)
module regs_busy_table
  import dlx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] set_idx,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rs3,
  input  logic [4:0] rd,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       rs3_busy,
  output logic       rd_busy,
  output logic       clr_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] rel_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] eff_busy;

  // One-hot masks; index 0 decodes to nothing so r0 is never tracked.
  always_comb begin
    rel_mask = '0;
    set_mask = '0;
    if (clr_idx != REG_ZERO) rel_mask[clr_idx] = 1'b1;
    if (set_idx != REG_ZERO) set_mask[set_idx] = 1'b1;
  end

  // A register released this cycle is forwarded by regs, so it reads as free.
  assign eff_busy = busy_q & ~rel_mask;

  assign rs1_busy = eff_busy[rs1];
  assign rs2_busy = eff_busy[rs2];
  assign rs3_busy = eff_busy[rs3];
  assign rd_busy  = eff_busy[rd];
  assign clr_busy = busy_q[clr_idx];

  // Set after clear so a same-register release+issue leaves the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= (eff_busy | set_mask) & ~NUM_REGS'(1);
    end
  end

endmodule

// File: rtl/regs_wb_sched.sv
// Scoreboard and write-port scheduler for the 3R/1W DLX register file.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   id_valid, id_rs1..3, id_use,        decode request and its sources/destination
//   id_wr, id_rd, id_long
//   id_stall                            decode must hold (combinational)
//   alu_wb_valid/rd/data                fixed-latency ALU writeback, highest priority
//   lu_wb_valid/rd/data, lu_wb_ready    long-unit writeback with handshake
//   rf_rd, rf_data                      to regs.Rd / regs.reg_in (r0 when idle)
//   err                                 sticky writeback-consistency error
module regs_wb_sched #(
  parameter int unsigned MAX_LONG = 4,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rs3,
  input  logic [2:0]      id_use,
  input  logic            id_wr,
  input  logic [4:0]      id_rd,
  input  logic            id_long,
  output logic            id_stall,
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  input  logic            lu_wb_valid,
  input  logic [4:0]      lu_wb_rd,
  input  logic [XLEN-1:0] lu_wb_data,
  output logic            lu_wb_ready,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            err
);

  import dlx_pkg::*;

  localparam int unsigned CNT_W = 4;

  wb_src_e          wb_src;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             lu_grant;

  logic [CNT_W-1:0] long_cnt_q;
  logic [CNT_W-1:0] long_cnt_d;
  logic             err_q;
  logic             err_d;

  logic             rs1_busy;
  logic             rs2_busy;
  logic             rs3_busy;
  logic             rd_busy;
  logic             clr_busy;
  logic             raw;
  logic             waw;
  logic             cap;
  logic             issue;
  logic [4:0]       set_idx;

  // Write-port arbitration: ALU cannot be back-pressured, so it always wins.
  // regs writes every edge, hence the idle default of r0 / zero data.
  always_comb begin
    wb_src  = WB_NONE;
    wb_rd   = REG_ZERO;
    wb_data = '0;
    if (!reset) begin
      if (alu_wb_valid) begin
        wb_src  = WB_ALU;
        wb_rd   = alu_wb_rd;
        wb_data = alu_wb_data;
      end else if (lu_wb_valid) begin
        wb_src  = WB_LU;
        wb_rd   = lu_wb_rd;
        wb_data = lu_wb_data;
      end
    end
  end

  assign lu_grant    = (wb_src == WB_LU);
  assign lu_wb_ready = lu_grant;
  assign rf_rd       = wb_rd;
  assign rf_data     = wb_data;

  regs_busy_table u_busy (
    .clk      (clk),
    .reset    (reset),
    .set_idx  (set_idx),
    .clr_idx  (wb_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs3      (id_rs3),
    .rd       (id_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rs3_busy (rs3_busy),
    .rd_busy  (rd_busy),
    .clr_busy (clr_busy)
  );

  // Hazard detection against the post-release busy view.
  always_comb begin
    raw = (id_use[0] && (id_rs1 != REG_ZERO) && rs1_busy) ||
          (id_use[1] && (id_rs2 != REG_ZERO) && rs2_busy) ||
          (id_use[2] && (id_rs3 != REG_ZERO) && rs3_busy);
    waw = id_wr && (id_rd != REG_ZERO) && rd_busy;
    // A long grant this cycle frees one slot for the incoming long op.
    cap = id_long && (long_cnt_q == CNT_W'(MAX_LONG)) && !lu_grant;
  end

  assign id_stall = reset || (id_valid && (raw || waw || cap));
  assign issue    = id_valid && !id_stall;
  assign set_idx  = (issue && id_wr) ? id_rd : REG_ZERO;

  // Outstanding long-op count; a long op with rd=0 still occupies a slot.
  always_comb begin
    long_cnt_d = long_cnt_q;
    if (issue && id_long && !lu_grant) begin
      long_cnt_d = long_cnt_q + CNT_W'(1);
    end else if (lu_grant && !(issue && id_long) && (long_cnt_q != '0)) begin
      long_cnt_d = long_cnt_q - CNT_W'(1);
    end
  end

  // Sticky error: release of a non-busy register, or both units naming one rd.
  always_comb begin
    err_d = err_q;
    if ((wb_src != WB_NONE) && (wb_rd != REG_ZERO) && !clr_busy) err_d = 1'b1;
    if (alu_wb_valid && lu_wb_valid && (alu_wb_rd == lu_wb_rd))  err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      long_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_regs_wb_sched.sv
// Self-checking bench for regs_wb_sched: per-cycle vector table plus a
// hand-written sequence, expectations pushed to a scoreboard queue.
module tb_regs_wb_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rs3;
  logic [2:0]  id_use;
  logic        id_wr;
  logic [4:0]  id_rd;
  logic        id_long;
  logic        id_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        lu_wb_valid;
  logic [4:0]  lu_wb_rd;
  logic [31:0] lu_wb_data;
  logic        lu_wb_ready;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  regs_wb_sched #(.MAX_LONG(4), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_use(id_use), .id_wr(id_wr), .id_rd(id_rd), .id_long(id_long),
    .id_stall(id_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .lu_wb_valid(lu_wb_valid), .lu_wb_rd(lu_wb_rd), .lu_wb_data(lu_wb_data),
    .lu_wb_ready(lu_wb_ready),
    .rf_rd(rf_rd), .rf_data(rf_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, idv;
    logic [4:0]  rs1, rs2, rs3;
    logic [2:0]  usem;
    logic        wr;
    logic [4:0]  rd;
    logic        lng, av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        e_stall, e_rdy;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  typedef struct {
    int          idx;
    logic        stall, rdy;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  vec_t hand[$];

  function automatic vec_t V(
    logic rst, logic idv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rs3,
    logic [2:0] usem, logic wr, logic [4:0] rd, logic lng,
    logic av, logic [4:0] ard, logic [31:0] adat,
    logic lv, logic [4:0] lrd, logic [31:0] ldat,
    logic es, logic er, logic [4:0] erd, logic [31:0] edat, logic eerr);
    vec_t v;
    v.rst = rst; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.rs3 = rs3;
    v.usem = usem; v.wr = wr; v.rd = rd; v.lng = lng;
    v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.e_stall = es; v.e_rdy = er; v.e_rd = erd; v.e_data = edat; v.e_err = eerr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; id_valid = v.idv;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs3 = v.rs3; id_use = v.usem;
    id_wr = v.wr; id_rd = v.rd; id_long = v.lng;
    alu_wb_valid = v.av; alu_wb_rd = v.ard; alu_wb_data = v.adat;
    lu_wb_valid = v.lv; lu_wb_rd = v.lrd; lu_wb_data = v.ldat;
  endtask

  task automatic check1(input int idx, input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL step %0d %s: got %0h expected %0h", idx, name, act, req);
    end
  endtask

  // Drive one cycle, queue its expectation, compare mid-cycle, advance.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    drive(v);
    e.idx = idx; e.stall = v.e_stall; e.rdy = v.e_rdy;
    e.rd = v.e_rd; e.data = v.e_data; e.err = v.e_err;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check1(idx, "scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check1(e.idx, "id_stall",    32'(id_stall),    32'(e.stall));
      check1(e.idx, "lu_wb_ready", 32'(lu_wb_ready), 32'(e.rdy));
      check1(e.idx, "rf_rd",       32'(rf_rd),       32'(e.rd));
      check1(e.idx, "rf_data",     rf_data,          e.data);
      check1(e.idx, "err",         32'(err),         32'(e.err));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst idv rs1 rs2 rs3 use wr rd lng | av ard adat | lv lrd ldat | stall rdy rd data err
    vecs.push_back(V(1,1, 0,0,0,3'b000,1, 5,0, 1, 3,32'h55, 0, 0,32'h0,  1,0, 0,32'h0, 0));  // 0 reset gates outputs
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 5,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 1 issue r5
    vecs.push_back(V(0,1, 5,0,0,3'b001,1, 6,0, 0, 0,32'h0,  0, 0,32'h0,  1,0, 0,32'h0, 0));  // 2 RAW on r5
    vecs.push_back(V(0,1, 5,0,0,3'b001,1, 6,0, 0, 0,32'h0,  0, 0,32'h0,  1,0, 0,32'h0, 0));  // 3
    vecs.push_back(V(0,1, 5,0,0,3'b001,1, 6,0, 1, 5,32'hAB, 0, 0,32'h0,  0,0, 5,32'hAB,0));  // 4 bypass release
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 1, 6,32'h66, 0, 0,32'h0,  0,0, 6,32'h66,0));  // 5
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 3,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 6 issue r3
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 7,1, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 7 long r7
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 1, 3,32'h11, 1, 7,32'h22, 0,0, 3,32'h11,0));  // 8 ALU wins
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  1, 7,32'h22, 0,1, 7,32'h22,0));  // 9 LU granted
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 10 idle -> r0
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 1,1, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 11 long r1
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 2,1, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 12 long r2
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 3,1, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 13 long r3
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 4,1, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 14 long r4
    vecs.push_back(V(0,1, 0,0,0,3'b000,1,10,1, 0, 0,32'h0,  0, 0,32'h0,  1,0, 0,32'h0, 0));  // 15 capacity
    vecs.push_back(V(0,1, 0,0,0,3'b000,1,10,1, 0, 0,32'h0,  0, 0,32'h0,  1,0, 0,32'h0, 0));  // 16
    vecs.push_back(V(0,1, 0,0,0,3'b000,1,10,1, 0, 0,32'h0,  1, 1,32'h01, 0,1, 1,32'h01,0));  // 17 slot freed
    vecs.push_back(V(0,1, 0,0,0,3'b000,1,11,1, 0, 0,32'h0,  0, 0,32'h0,  1,0, 0,32'h0, 0));  // 18 count held at 4
    vecs.push_back(V(0,1, 0,0,0,3'b111,1, 0,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 19 r0 only
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 20
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  1, 2,32'h02, 0,1, 2,32'h02,0));  // 21 drain
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  1, 3,32'h03, 0,1, 3,32'h03,0));  // 22
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  1, 4,32'h04, 0,1, 4,32'h04,0));  // 23
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  1,10,32'h0A, 0,1,10,32'h0A,0));  // 24
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 9,1, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 25 long r9
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 9,0, 0, 0,32'h0,  0, 0,32'h0,  1,0, 0,32'h0, 0));  // 26 WAW
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 9,0, 0, 0,32'h0,  0, 0,32'h0,  1,0, 0,32'h0, 0));  // 27
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 9,0, 0, 0,32'h0,  1, 9,32'h99, 0,1, 9,32'h99,0));  // 28 issue on release
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 9,0, 0, 0,32'h0,  0, 0,32'h0,  1,0, 0,32'h0, 0));  // 29 r9 re-marked
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 1, 9,32'h90, 0, 0,32'h0,  0,0, 9,32'h90,0));  // 30
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 8,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 31 issue r8
    vecs.push_back(V(0,1, 8,8,0,3'b100,0, 0,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 32 unused srcs
    vecs.push_back(V(0,1, 0,0,8,3'b100,0, 0,0, 0, 0,32'h0,  0, 0,32'h0,  1,0, 0,32'h0, 0));  // 33 RAW on rs3
    vecs.push_back(V(0,1, 0,0,8,3'b100,0, 0,0, 1, 8,32'h88, 0, 0,32'h0,  0,0, 8,32'h88,0));  // 34
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 1,12,32'h0C, 0, 0,32'h0,  0,0,12,32'h0C,0));  // 35 spurious wb
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 1));  // 36 err sticky
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 1));  // 37
    vecs.push_back(V(0,1, 0,0,0,3'b000,1, 5,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 1));  // 38 issue r5
    vecs.push_back(V(1,1, 5,0,0,3'b001,0, 0,0, 0, 0,32'h0,  0, 0,32'h0,  1,0, 0,32'h0, 1));  // 39 reset mid-op
    vecs.push_back(V(0,1, 5,0,0,3'b001,0, 0,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 40 tracking dropped
    vecs.push_back(V(0,1, 0,0,0,3'b000,1,13,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));  // 41 issue r13
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 1,13,32'hD1, 1,13,32'hD2, 0,0,13,32'hD1,0));  // 42 same-rd clash
    vecs.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 1));  // 43

    // Long result held across two ALU-owned cycles, then accepted.
    hand.push_back(V(1,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  0, 0,32'h0,  1,0, 0,32'h0, 1));
    hand.push_back(V(0,1, 0,0,0,3'b000,1,20,1, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));
    hand.push_back(V(0,1, 0,0,0,3'b000,1,21,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));
    hand.push_back(V(0,1, 0,0,0,3'b000,1,22,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));
    hand.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 1,21,32'h21, 1,20,32'h20, 0,0,21,32'h21,0));
    hand.push_back(V(0,1, 0,20,0,3'b010,0,0,0, 1,22,32'h22, 1,20,32'h20, 1,0,22,32'h22,0));
    hand.push_back(V(0,1, 0,20,0,3'b010,0,0,0, 0, 0,32'h0,  1,20,32'h20, 0,1,20,32'h20,0));
    hand.push_back(V(0,0, 0,0,0,3'b000,0, 0,0, 0, 0,32'h0,  0, 0,32'h0,  0,0, 0,32'h0, 0));

    drive(V(1,0,0,0,0,3'b000,0,0,0,0,0,32'h0,0,0,32'h0,0,0,0,32'h0,0));
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
    for (int i = 0; i < hand.size(); i++) apply(100 + i, hand[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
